// File: rtl/stream_fifo_pkt.sv
// stream_fifo_pkt: AXI4-Stream FIFO with a registered first-word-fall-through output,
// fill-level and packet-count status, and optional store-and-forward packet mode
// with forced cut-through when a single packet fills the whole FIFO.
module stream_fifo_pkt #(
  parameter int unsigned AW       = 4,
  parameter int unsigned DW       = 8,
  parameter int unsigned PKT_MODE = 0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] d_in,
  input  logic          d_in_valid,
  input  logic          d_in_last,
  output logic          d_in_ready,
  output logic [DW-1:0] d_out,
  output logic          d_out_valid,
  output logic          d_out_last,
  input  logic          d_out_ready,
  output logic [AW:0]   level,
  output logic [AW:0]   pkt_count
);

  localparam int unsigned DEPTH    = 1 << AW;
  localparam int unsigned LW       = AW + 1;
  localparam int unsigned MW       = DW + 1;
  localparam logic [AW:0] FULL_LVL = LW'(DEPTH);

  logic [MW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          cut;
  logic          accept;
  logic          pop;
  logic          rel;
  logic          load;
  logic [AW:0]   mem_cnt;

  // Handshakes and output-register refill decision
  assign d_in_ready = rst_n & (level < FULL_LVL);
  assign accept     = d_in_valid & d_in_ready;
  assign pop        = d_out_valid & d_out_ready;
  // Words still in memory: the output register holds one of the counted words when valid
  assign mem_cnt    = level - LW'(d_out_valid);
  assign rel        = (PKT_MODE == 0) || (pkt_count != '0) || cut;
  assign load       = (!d_out_valid || pop) && (mem_cnt != '0) && rel;

  // Memory write of {last, data}; contents need no reset since pointers gate reads
  always_ff @(posedge clk) begin
    if (accept) begin
      mem[wr_ptr] <= {d_in_last, d_in};
    end
  end

  // Write pointer, wraps modulo the memory depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
    end else if (accept) begin
      wr_ptr <= wr_ptr + AW'(1);
    end
  end

  // Output register: refill from memory when empty or being popped, else hold
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr      <= '0;
      d_out       <= '0;
      d_out_last  <= 1'b0;
      d_out_valid <= 1'b0;
    end else if (load) begin
      d_out       <= mem[rd_ptr][DW-1:0];
      d_out_last  <= mem[rd_ptr][DW];
      d_out_valid <= 1'b1;
      rd_ptr      <= rd_ptr + AW'(1);
    end else if (pop) begin
      d_out_valid <= 1'b0;
    end
  end

  // Fill level counts memory plus output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Complete packets held: last word in, last word out
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count <= '0;
    end else begin
      case ({accept && d_in_last, pop && d_out_last})
        2'b10:   pkt_count <= pkt_count + LW'(1);
        2'b01:   pkt_count <= pkt_count - LW'(1);
        default: pkt_count <= pkt_count;
      endcase
    end
  end

  // Cut-through latch: a full FIFO with no complete packet would otherwise deadlock
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cut <= 1'b0;
    end else if (pop && d_out_last) begin
      cut <= 1'b0;
    end else if ((PKT_MODE != 0) && (level == FULL_LVL) && (pkt_count == '0)) begin
      cut <= 1'b1;
    end
  end

endmodule
